// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator request scheduler.
package elevator_pkg;

  localparam int NUM_FLOORS = 8;
  localparam int FLOOR_W    = 3;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SERVE_UP   = 2'd1,
    SERVE_DOWN = 2'd2,
    DOOR_OPEN  = 2'd3
  } sched_state_t;

endpackage

// File: rtl/elevator_floor_search.sv
// Combinational LOOK search over the pending-call vector: nearest pending
// floor strictly above and strictly below the car, plus a hit on the car's
// own floor. Out-of-range car positions simply find nothing above/hit.
module elevator_floor_search #(
  parameter int NUM_FLOORS = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W    = elevator_pkg::FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  above_found,
  output logic [FLOOR_W-1:0]    above_floor,
  output logic                  below_found,
  output logic [FLOOR_W-1:0]    below_floor,
  output logic                  hit_found
);

  // Scan floors; the last match written wins, so scan direction picks nearest.
  always_comb begin
    // NOTE: every output gets a default before the loops so no path can
    // leave a value unassigned, which would otherwise infer a latch.
    above_found = 1'b0;
    above_floor = '0;
    below_found = 1'b0;
    below_floor = '0;
    hit_found   = 1'b0;
    // Descending scan: the lowest floor above the car is written last.
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pending[i] && (i > int'(current_floor))) begin
        above_found = 1'b1;
        above_floor = FLOOR_W'(i);
      end
    end
    // Ascending scan: the highest floor below the car is written last.
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pending[i] && (i < int'(current_floor))) begin
        below_found = 1'b1;
        below_floor = FLOOR_W'(i);
      end
      if (pending[i] && (i == int'(current_floor))) begin
        hit_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/elevator_request_scheduler.sv
// LOOK-style elevator scheduler: latches floor calls, issues the nearest
// destination in the current sweep direction, and times the door dwell.
// All outputs are registered; next values are computed from next_state.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS  = elevator_pkg::NUM_FLOORS,
  parameter int FLOOR_W     = elevator_pkg::FLOOR_W,
  parameter int DOOR_CYCLES = 4   // dwell length, must be at least 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic [FLOOR_W-1:0]    current_floor,
  output logic                  target_valid,
  output logic [FLOOR_W-1:0]    target_floor,
  output logic [1:0]            direction,
  output logic                  door_open,
  output logic [NUM_FLOORS-1:0] pending
);

  import elevator_pkg::*;

  localparam int             CNT_W      = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DOOR_CYCLES - 1);

  sched_state_t          state, state_next;
  dir_t                  dir_q, dir_next;
  logic [CNT_W-1:0]      dwell, dwell_next;
  logic [NUM_FLOORS-1:0] pending_next;
  logic                  target_valid_next;
  logic [FLOOR_W-1:0]    target_floor_next;
  logic                  door_open_next;

  logic                  above_found, below_found, hit_found;
  logic [FLOOR_W-1:0]    above_floor, below_floor;

  logic                  floor_ok;
  logic [NUM_FLOORS-1:0] cur_mask;
  logic                  arrive;
  logic                  cur_call;
  logic                  dwell_done;
  logic                  dwell_running;
  logic                  clear_cur;
  logic                  mask_call;

  elevator_floor_search #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_search (
    .pending       (pending),
    .current_floor (current_floor),
    .above_found   (above_found),
    .above_floor   (above_floor),
    .below_found   (below_found),
    .below_floor   (below_floor),
    .hit_found     (hit_found)
  );

  // A floor index the car controller should never report freezes the block.
  assign floor_ok   = int'(current_floor) < NUM_FLOORS;
  assign cur_mask   = NUM_FLOORS'(1) << current_floor;
  assign arrive     = (current_floor == target_floor) && hit_found;
  assign cur_call   = (state == DOOR_OPEN) && (|(call_req & cur_mask));
  assign dwell_done = (dwell == '0);

  // Door keeps counting down (no reload, no clear) while this is set.
  assign dwell_running = (state == DOOR_OPEN) && !cur_call && !dwell_done;
  // Fresh entry into DOOR_OPEN at this floor, including a re-open after a
  // finished dwell; a dwell reload by a repeat call is not an entry.
  assign clear_cur     = (state_next == DOOR_OPEN) &&
                         !((state == DOOR_OPEN) && (cur_call || !dwell_done));
  // Calls for the car's floor are absorbed while the door is, or becomes, open.
  assign mask_call     = (state == DOOR_OPEN) || clear_cur;
  assign direction     = dir_q;

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= '0;
      target_valid <= 1'b0;
      target_floor <= '0;
      dir_q        <= DIR_IDLE;
      door_open    <= 1'b0;
      dwell        <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state        <= state_next;
      pending      <= pending_next;
      target_valid <= target_valid_next;
      target_floor <= target_floor_next;
      dir_q        <= dir_next;
      door_open    <= door_open_next;
      dwell        <= dwell_next;
    end
  end

  // Next-state selection: LOOK sweep with up priority on ties.
  always_comb begin
    state_next = state;
    if (floor_ok) begin
      unique case (state)
        IDLE: begin
          if (above_found)      state_next = SERVE_UP;
          else if (below_found) state_next = SERVE_DOWN;
          else if (hit_found)   state_next = DOOR_OPEN;
        end
        SERVE_UP: begin
          if (arrive)               state_next = DOOR_OPEN;
          else if (pending == '0)   state_next = IDLE;
          else if (above_found)     state_next = SERVE_UP;
          else if (below_found)     state_next = SERVE_DOWN;
          else                      state_next = DOOR_OPEN;
        end
        SERVE_DOWN: begin
          if (arrive)               state_next = DOOR_OPEN;
          else if (pending == '0)   state_next = IDLE;
          else if (below_found)     state_next = SERVE_DOWN;
          else if (above_found)     state_next = SERVE_UP;
          else                      state_next = DOOR_OPEN;
        end
        DOOR_OPEN: begin
          if (cur_call || !dwell_done) begin
            state_next = DOOR_OPEN;
          end else if (dir_q == DIR_DOWN) begin
            if (below_found)      state_next = SERVE_DOWN;
            else if (above_found) state_next = SERVE_UP;
            else if (hit_found)   state_next = DOOR_OPEN;
            else                  state_next = IDLE;
          end else begin
            if (above_found)      state_next = SERVE_UP;
            else if (below_found) state_next = SERVE_DOWN;
            else if (hit_found)   state_next = DOOR_OPEN;
            else                  state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs, derived from the chosen state.
  always_comb begin
    pending_next      = pending;
    target_valid_next = target_valid;
    target_floor_next = target_floor;
    dir_next          = dir_q;
    door_open_next    = door_open;
    dwell_next        = dwell;
    if (floor_ok) begin
      pending_next = (pending  & ~(clear_cur ? cur_mask : '0)) |
                     (call_req & ~(mask_call ? cur_mask : '0));
      unique case (state_next)
        IDLE: begin
          target_valid_next = 1'b0;
          dir_next          = DIR_IDLE;
          door_open_next    = 1'b0;
          dwell_next        = '0;
        end
        SERVE_UP: begin
          target_valid_next = 1'b1;
          target_floor_next = above_floor;
          dir_next          = DIR_UP;
          door_open_next    = 1'b0;
        end
        SERVE_DOWN: begin
          target_valid_next = 1'b1;
          target_floor_next = below_floor;
          dir_next          = DIR_DOWN;
          door_open_next    = 1'b0;
        end
        DOOR_OPEN: begin
          target_valid_next = 1'b0;
          door_open_next    = 1'b1;
          dwell_next        = dwell_running ? (dwell - CNT_W'(1)) : DWELL_LOAD;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_FLOORS, 8, number of served floors.
- FLOOR_W, 3, floor index width.
- DOOR_CYCLES, 4, door-open dwell in clk cycles; must be at least 1.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- call_req, in, NUM_FLOORS, one-cycle call pulses; bit i is a call to floor i; multiple bits allowed.
- current_floor, in, FLOOR_W, floor the car is at, driven by the car controller.
- target_valid, out, 1, target_floor is a live destination.
- target_floor, out, FLOOR_W, destination issued to the car controller.
- direction, out, 2, sweep direction: DIR_IDLE=0, DIR_UP=1, DIR_DOWN=2.
- door_open, out, 1, door dwell in progress.
- pending, out, NUM_FLOORS, latched outstanding calls.

Function
REQ-003 The block SHALL set a call_req bit into pending at the clock edge; the bit is visible on the cycle after the pulse.
REQ-004 A pending bit SHALL clear only on entry to DOOR_OPEN at that floor.
REQ-005 The block SHALL implement the FSM states IDLE, SERVE_UP, SERVE_DOWN and DOOR_OPEN, all registered; every output is a register.
REQ-006 IDLE with pending nonzero SHALL choose its next state in this priority order:
- any pending floor above current_floor: go to SERVE_UP.
- else any pending floor below: go to SERVE_DOWN.
- else only the current floor pending: go to DOOR_OPEN.
REQ-007 Up SHALL have priority when calls exist both above and below current_floor.
REQ-008 In SERVE_UP, target_floor SHALL be the lowest pending floor strictly above current_floor (LOOK), with target_valid=1 and direction=DIR_UP; it re-evaluates every cycle, so a new nearer call preempts the current target.
REQ-009 SERVE_DOWN SHALL mirror SERVE_UP, using the highest pending floor strictly below current_floor and direction=DIR_DOWN.
REQ-010 In SERVE_UP or SERVE_DOWN, when current_floor equals target_floor and that bit is pending, the block SHALL, at the next edge:
- enter DOOR_OPEN and assert door_open.
- clear the pending bit.
- deassert target_valid.
- load the dwell counter with DOOR_CYCLES-1.
REQ-011 In DOOR_OPEN the dwell counter SHALL decrement each cycle; door_open SHALL stay high for exactly DOOR_CYCLES cycles.
REQ-012 When the counter reaches 0, the next state SHALL be chosen in this priority order:
- pending floors remain in the stored direction: continue in that direction.
- else pending floors remain in the opposite direction: reverse.
- else pending is only the current floor: DOOR_OPEN again.
- else: IDLE with direction=DIR_IDLE.
REQ-013 A call_req for current_floor during DOOR_OPEN SHALL NOT set pending, and SHALL reload the counter with DOOR_CYCLES-1.
REQ-014 A call_req for current_floor in the same cycle as its clear SHALL be absorbed; it SHALL NOT be re-latched.
REQ-015 If pending becomes empty in SERVE_UP or SERVE_DOWN without an arrival, the block SHALL go to IDLE and deassert target_valid.
REQ-016 call_req bits at or above NUM_FLOORS SHALL be ignored.
REQ-017 A current_floor value at or above NUM_FLOORS SHALL hold the state and outputs unchanged.

Reset
REQ-018 Asserting rst SHALL immediately force:
- state to IDLE;
- pending, target_valid, target_floor and door_open to 0;
- direction to DIR_IDLE;
- the dwell counter to 0.
This applies in every state, including mid-DOOR_OPEN.
REQ-019 The first call_req sampled after rst deasserts SHALL be latched normally.

Structure
REQ-020 Package elevator_pkg SHALL hold NUM_FLOORS, FLOOR_W, dir_t {DIR_IDLE, DIR_UP, DIR_DOWN} and sched_state_t {IDLE, SERVE_UP, SERVE_DOWN, DOOR_OPEN}.
REQ-021 Sub-module elevator_floor_search SHALL be combinational and, given pending and current_floor, return:
- nearest-above found flag and floor;
- nearest-below found flag and floor;
- a current-floor-hit flag.

Verification
REQ-022 Reset: assert rst mid-DOOR_OPEN -> all outputs are 0 / DIR_IDLE with no clock edge; calls latch normally after release.
REQ-023 Idle at floor 0, call_req=8'h20:
- +1 cycle: pending=8'h20.
- +2 cycles: target_valid=1, target_floor=5, DIR_UP.
- Set current_floor=5: next edge door_open=1 for 4 cycles and pending=0, then IDLE with target_valid=0.
REQ-024 Preemption: at floor 3 in SERVE_UP, pending=8'h42 (floors 1 and 6); pulse a call at floor 4 -> target_floor becomes 4. Expected service order is 4, then 6, then reverse to DIR_DOWN with target 1.
REQ-025 Idle at floor 2, call floor 2 -> DOOR_OPEN with no target_valid. A repeat call at floor 2 in the third dwell cycle -> door_open stays high for 4 more cycles.
REQ-026 Tie: idle at floor 4, calls at floors 2 and 6 in the same cycle -> SERVE_UP with target 6; after the dwell, SERVE_DOWN with target 2.
